mid_bram_ring: RTL and testbench
================================

# mid_bram_ring

Parametrised multi-channel row ring buffer between two convolution stages. Captures raster rows from the upstream stage (`de_in` framed, `CH` channels per beat) into `BANKS` row banks round-robin, and exposes all banks in parallel to the downstream window reader. Adds credit-based bank occupancy, overflow and row-length error detection, and frame tracking over the fixed four-bank, three-channel buffer it replaces.

## Interface
- `DATA_W`, 21: bits per channel sample
- `CH`, 3: channels per beat
- `BANKS`, 4: row banks, ≥2
- `IMG_W`, 28: beats per row
- `IMG_H`, 28: rows per frame
- `ADDR_W`, 11: bank address width, 2^ADDR_W ≥ IMG_W

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `RESET`  in  1  synchronous, active-high
- `start_wr`  in  1  write-side enable; low = write side idle
- `de_in`  in  1  data valid, high for one row of beats
- `din`  in  CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
- `rd_en`  in  1  read strobe, all banks
- `rd_addr`  in  ADDR_W  read column
- `rel_row`  in  1  consumer releases oldest row (1-cycle pulse)
- `dout`  out  BANKS*CH*DATA_W  slot s, channel c at [(s*CH+c)*DATA_W +: DATA_W]
- `row_done`  out  1  pulse: row committed
- `frame_done`  out  1  pulse: row IMG_H-1 committed
- `occ`  out  $clog2(BANKS+1)  committed, unreleased rows
- `full`  out  1  occ == BANKS
- `wr_bank`  out  $clog2(BANKS)  bank for next/current row
- `rd_base`  out  $clog2(BANKS)  oldest committed bank
- `ovf_err`  out  1  sticky: row arrived while full
- `len_err`  out  1  sticky: committed row length ≠ IMG_W

## Operation
- Write: at each posedge with `start_wr`=1 and `de_in`=1, `din` is written to bank `wr_bank` at `wr_addr`; `wr_addr` increments. Beats beyond IMG_W-1 are dropped and set `len_err`.
- Row start (`de_in` 0→1) while `full`: entire row dropped, `ovf_err` set, no commit, `wr_bank` unchanged.
- Row end (registered `de_q`=1, `de_in`=0, row not dropped): commit. `occ`+1, `wr_bank`+1 mod BANKS, `wr_addr`←0, row counter +1 (wraps IMG_H-1→0 with `frame_done`). A beat count ≠ IMG_W sets `len_err`; the row is still committed.
- `rel_row` with `occ`>0: `occ`−1, `rd_base`+1 mod BANKS. `rel_row` with `occ`=0 is ignored.
- Commit and release in the same cycle: `occ` unchanged, both pointers advance.
- `start_wr` low: `de_in` ignored. A row in progress is abandoned (no commit, `wr_addr`←0). Row counter cleared. `occ`, `rd_base`, `wr_bank` and error flags held.
- Read: `rd_en`=1 registers all banks at `rd_addr` into `dout`. `rd_en`=0 holds `dout`. Reading the bank under write at the written address returns the previous contents (read-before-write).
- `RESET`: all counters, pointers, flags and `dout` go to 0. Bank contents are not cleared.

## Timing
- Write latency: the sample is stored at the posedge it is presented.
- `row_done`, `frame_done`, `occ`, `wr_bank` update one cycle after the first low `de_in` cycle.
- `full` and `occ` are registered. A row starting on the cycle after a `rel_row` from full is accepted.
- Read latency is 1 cycle: `rd_addr` sampled at edge N, `dout` valid after edge N.
- All outputs are 0 after reset. Error flags clear only on `RESET`.

## Configuration
- `MID_BRAM_ROTATE_EN` defined: `dout` slot s carries physical bank (`rd_base`+s) mod BANKS, using `rd_base` sampled with `rd_en`. Slot 0 is always the oldest row.
- Undefined: slot s = physical bank s. The consumer uses `rd_base` itself.

## Test plan
- Reset, then 4 rows of 28 beats, channel data = row*100+col → 4 `row_done` pulses, `occ`=4, `full`=1; rd_addr=5 → slot b ch0 = b*100+5 (both macro settings).
- Full buffer, 5th row → `ovf_err`=1, `occ` stays 4, bank 0 keeps row 0. Then `rel_row`, 6th row → lands in bank 0, `occ`=4, `rd_base`=1. With ROTATE_EN, slot 0 = row 1.
- `rel_row` on the same cycle as a row-end commit at `occ`=2 → `occ`=2, `rd_base` and `wr_bank` both +1.
- 28 rows with one release per row → `frame_done` once, after row 27. Row counter wraps and the next row gives no `frame_done`.
- Row of 30 beats, then a row of 20 beats → both committed, `len_err`=1; column 28/29 data absent.
- `start_wr` dropped mid-row at beat 10 → no `row_done`, `wr_bank` unchanged; `RESET` mid-row → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/mid_bram_ring.sv
// Multi-channel row ring buffer between two convolution stages: BANKS row banks, credit occupancy, error flags.
// Optional MID_BRAM_ROTATE_EN: dout slot 0 always carries the oldest committed row.
module mid_bram_ring #(
  parameter int DATA_W = 21,
  parameter int CH     = 3,
  parameter int BANKS  = 4,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 11
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          start_wr,
  input  logic                          de_in,
  input  logic [CH*DATA_W-1:0]          din,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic                          rel_row,
  output logic [BANKS*CH*DATA_W-1:0]    dout,
  output logic                          row_done,
  output logic                          frame_done,
  output logic [$clog2(BANKS+1)-1:0]    occ,
  output logic                          full,
  output logic [$clog2(BANKS)-1:0]      wr_bank,
  output logic [$clog2(BANKS)-1:0]      rd_base,
  output logic                          ovf_err,
  output logic                          len_err
);
  localparam int OW    = $clog2(BANKS+1);
  localparam int BW    = $clog2(BANKS);
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WW    = CH*DATA_W;
  localparam int DEPTH = 2**ADDR_W;

  logic                     de_q, drop_q, rd_vld;
  logic [ADDR_W:0]          wr_addr;
  logic [RW-1:0]            row_cnt;
  logic                     row_start, dropping, wr_fire, wr_mem, commit, rel_ok;
  logic [BANKS-1:0][WW-1:0] bank_q, slot_d;

  assign full      = (occ == OW'(BANKS));
  assign row_start = de_in & ~de_q;
  // a row is rejected as a whole at its first beat if no bank is free
  assign dropping  = row_start ? full : drop_q;
  assign wr_fire   = start_wr & de_in & ~dropping;
  assign wr_mem    = wr_fire & ~RESET & (wr_addr < (ADDR_W+1)'(IMG_W));
  assign commit    = start_wr & de_q & ~de_in & ~drop_q;
  assign rel_ok    = rel_row & (occ != '0);

  always_ff @(posedge clk) begin
    if (RESET) begin
      de_q       <= 1'b0;
      drop_q     <= 1'b0;
      wr_addr    <= '0;
      row_cnt    <= '0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      occ        <= '0;
      wr_bank    <= '0;
      rd_base    <= '0;
      ovf_err    <= 1'b0;
      len_err    <= 1'b0;
      rd_vld     <= 1'b0;
    end else begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      if (rd_en) rd_vld <= 1'b1;
      if (!start_wr) begin
        de_q    <= 1'b0;
        drop_q  <= 1'b0;
        wr_addr <= '0;
        row_cnt <= '0;
      end else begin
        de_q   <= de_in;
        drop_q <= de_in & dropping;
        if (row_start && full) ovf_err <= 1'b1;
        if (wr_fire) begin
          if (wr_addr >= (ADDR_W+1)'(IMG_W)) len_err <= 1'b1;
          // saturate so an overlong row can never alias back to IMG_W
          if (wr_addr != '1) wr_addr <= wr_addr + (ADDR_W+1)'(1);
        end
        if (commit) begin
          row_done <= 1'b1;
          wr_addr  <= '0;
          wr_bank  <= (wr_bank == BW'(BANKS-1)) ? '0 : wr_bank + BW'(1);
          if (wr_addr != (ADDR_W+1)'(IMG_W)) len_err <= 1'b1;
          if (row_cnt == RW'(IMG_H-1)) begin
            frame_done <= 1'b1;
            row_cnt    <= '0;
          end else begin
            row_cnt <= row_cnt + RW'(1);
          end
        end
      end
      if (commit && !rel_ok)      occ <= occ + OW'(1);
      else if (!commit && rel_ok) occ <= occ - OW'(1);
      if (rel_ok) rd_base <= (rd_base == BW'(BANKS-1)) ? '0 : rd_base + BW'(1);
    end
  end

  // banks have no reset so they map onto block RAM; read-before-write on collision
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WW-1:0] mem [DEPTH];
    logic [WW-1:0] q;
    always_ff @(posedge clk) begin
      if (wr_mem && wr_bank == BW'(b)) mem[wr_addr[ADDR_W-1:0]] <= din;
      if (rd_en) q <= mem[rd_addr];
    end
    assign bank_q[b] = q;
  end

`ifdef MID_BRAM_ROTATE_EN
  logic [BW-1:0] base_q;
  always_ff @(posedge clk) begin
    if (RESET)      base_q <= '0;
    else if (rd_en) base_q <= rd_base;
  end
  always_comb begin
    int k;
    k      = 0;
    slot_d = '0;
    for (int s = 0; s < BANKS; s++) begin
      k = int'(base_q) + s;
      if (k >= BANKS) k = k - BANKS;
      slot_d[s] = bank_q[BW'(k)];
    end
  end
`else
  assign slot_d = bank_q;
`endif

  // bank read registers are unreset; mask them until the first read after reset
  assign dout = rd_vld ? slot_d : '0;
endmodule

// File: tb/tb_mid_bram_ring.sv
// Scoreboard bench for mid_bram_ring: a behavioural model of banks/credits predicts every output.
module tb_mid_bram_ring;
  localparam int DATA_W = 21, CH = 3, BANKS = 4, IMG_W = 28, IMG_H = 28, ADDR_W = 11;
  localparam int OW = $clog2(BANKS+1), BW = $clog2(BANKS);

  logic                       clk = 1'b0;
  logic                       RESET, start_wr, de_in, rd_en, rel_row;
  logic [CH*DATA_W-1:0]       din;
  logic [ADDR_W-1:0]          rd_addr;
  logic [BANKS*CH*DATA_W-1:0] dout;
  logic                       row_done, frame_done, full, ovf_err, len_err;
  logic [OW-1:0]              occ;
  logic [BW-1:0]              wr_bank, rd_base;

  mid_bram_ring #(.DATA_W(DATA_W), .CH(CH), .BANKS(BANKS), .IMG_W(IMG_W),
                  .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .RESET(RESET), .start_wr(start_wr), .de_in(de_in), .din(din),
    .rd_en(rd_en), .rd_addr(rd_addr), .rel_row(rel_row), .dout(dout),
    .row_done(row_done), .frame_done(frame_done), .occ(occ), .full(full),
    .wr_bank(wr_bank), .rd_base(rd_base), .ovf_err(ovf_err), .len_err(len_err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int mm [BANKS][IMG_W];
  int m_occ, m_wb, m_rb, m_row;
  bit m_ovf, m_len;
  int expq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [CH*DATA_W-1:0] beat(input int r, input int i);
    logic [CH*DATA_W-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) v[c*DATA_W +: DATA_W] = DATA_W'(r*100 + i + 10000*c);
    return v;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".occ"},  64'(occ),     64'(m_occ));
    chk({tag, ".full"}, 64'(full),    64'(m_occ == BANKS));
    chk({tag, ".wb"},   64'(wr_bank), 64'(m_wb));
    chk({tag, ".rb"},   64'(rd_base), 64'(m_rb));
    chk({tag, ".ovf"},  64'(ovf_err), 64'(m_ovf));
    chk({tag, ".len"},  64'(len_err), 64'(m_len));
  endtask

  task automatic send_row(input int r, input int n, input bit rel_end);
    bit drop, rel_ok, exp_fd;
    drop   = (m_occ == BANKS);
    exp_fd = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); de_in = 1'b1; din = beat(r, i);
      if (!drop && i < IMG_W) mm[m_wb][i] = r*100 + i;
    end
    @(negedge clk); de_in = 1'b0; rel_row = rel_end;
    @(negedge clk); rel_row = 1'b0;
    rel_ok = rel_end && (m_occ > 0);
    if (drop) m_ovf = 1'b1;
    else begin
      if (n != IMG_W) m_len = 1'b1;
      exp_fd = (m_row == IMG_H-1);
      m_row  = (m_row + 1) % IMG_H;
      m_wb   = (m_wb + 1) % BANKS;
      m_occ++;
    end
    if (rel_ok) begin m_occ--; m_rb = (m_rb + 1) % BANKS; end
    chk($sformatf("row%0d.done", r),  64'(row_done),   64'(!drop));
    chk($sformatf("row%0d.frame", r), 64'(frame_done), 64'(exp_fd));
    check_state($sformatf("row%0d", r));
  endtask

  task automatic release_row();
    @(negedge clk); rel_row = 1'b1;
    @(negedge clk); rel_row = 1'b0;
    if (m_occ > 0) begin m_occ--; m_rb = (m_rb + 1) % BANKS; end
    check_state("rel");
  endtask

  task automatic rd(input int addr);
    int bank;
    @(negedge clk); rd_en = 1'b1; rd_addr = ADDR_W'(addr);
    for (int s = 0; s < BANKS; s++) begin
`ifdef MID_BRAM_ROTATE_EN
      bank = (m_rb + s) % BANKS;
`else
      bank = s;
`endif
      for (int c = 0; c < CH; c++) expq.push_back(mm[bank][addr] + 10000*c);
    end
    @(negedge clk); rd_en = 1'b0;
    for (int s = 0; s < BANKS; s++)
      for (int c = 0; c < CH; c++)
        chk($sformatf("rd%0d.s%0d.c%0d", addr, s, c),
            64'(dout[(s*CH+c)*DATA_W +: DATA_W]), 64'(expq.pop_front()));
  endtask

  task automatic model_reset();
    m_occ = 0; m_wb = 0; m_rb = 0; m_row = 0; m_ovf = 1'b0; m_len = 1'b0;
  endtask

  initial begin
    bit seen;
    RESET = 1'b1; start_wr = 1'b0; de_in = 1'b0; rd_en = 1'b0; rel_row = 1'b0;
    rd_addr = '0; din = '0;
    model_reset();
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    check_state("rst");
    chk("rst.dout", 64'(|dout), 64'd0);
    chk("rst.done", 64'(row_done | frame_done), 64'd0);
    start_wr = 1'b1;

    for (int r = 0; r < 4; r++) send_row(r, IMG_W, 1'b0);
    rd(5);

    send_row(4, IMG_W, 1'b0);          // arrives while full
    rd(0);

    release_row();
    send_row(5, IMG_W, 1'b0);
    rd(5);

    release_row();
    release_row();
    send_row(6, IMG_W, 1'b1);          // commit and release together at occ=2

    // abandon a row by dropping start_wr after 10 beats
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); de_in = 1'b1; din = beat(7, i); mm[m_wb][i] = 700 + i;
      seen |= row_done;
    end
    @(negedge clk); start_wr = 1'b0; seen |= row_done;
    @(negedge clk); de_in = 1'b0; seen |= row_done;
    repeat (2) begin @(negedge clk); seen |= row_done; end
    start_wr = 1'b1;
    m_row = 0;
    chk("abort.done", 64'(seen), 64'd0);
    check_state("abort");

    for (int r = 10; r < 10 + IMG_H; r++) send_row(r, IMG_W, 1'b1);
    send_row(38, IMG_W, 1'b1);         // first row of next frame
    rd(20);

    send_row(39, 30, 1'b1);
    send_row(40, 20, 1'b1);
    rd(27);
    rd(25);

    // reset in the middle of a row
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); de_in = 1'b1; din = beat(41, i); mm[m_wb][i] = 4100 + i;
    end
    @(negedge clk); RESET = 1'b1;
    @(negedge clk); RESET = 1'b0; de_in = 1'b0;
    model_reset();
    check_state("mrst");
    chk("mrst.dout", 64'(|dout), 64'd0);
    chk("mrst.done", 64'(row_done | frame_done), 64'd0);
    rd(3);                             // bank contents survive reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
